// File: rtl/bitwise_logic_seq.sv
// Multi-cycle bitwise AND/OR/XOR/NOR unit: SLICE bits per cycle, start/done handshake.
// Optional zero-result flag enabled by defining BITLOGIC_ZERO_FLAG_EN.
module bitwise_logic_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             done_q, done_d;
  logic [SLICE-1:0] a_sl, b_sl, f_sl;

  assign a_sl = a_q[int'(cnt_q)*SLICE +: SLICE];
  assign b_sl = b_q[int'(cnt_q)*SLICE +: SLICE];

  always_comb begin
    case (op_q)
      2'b00:   f_sl = a_sl & b_sl;
      2'b01:   f_sl = a_sl | b_sl;
      2'b10:   f_sl = a_sl ^ b_sl;
      default: f_sl = ~(a_sl | b_sl);
    endcase
  end

`ifdef BITLOGIC_ZERO_FLAG_EN
  // nz_q remembers whether any slice written so far was non-zero.
  logic nz_q, nz_d, zero_q, zero_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    done_d  = 1'b0;
`ifdef BITLOGIC_ZERO_FLAG_EN
    nz_d    = nz_q;
    zero_d  = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef BITLOGIC_ZERO_FLAG_EN
          nz_d    = 1'b0;
          zero_d  = 1'b0;
`endif
        end
      end
      default: begin
        res_d[int'(cnt_q)*SLICE +: SLICE] = f_sl;
`ifdef BITLOGIC_ZERO_FLAG_EN
        nz_d = nz_q | (|f_sl);
`endif
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef BITLOGIC_ZERO_FLAG_EN
          zero_d  = ~(nz_q | (|f_sl));
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

`ifdef BITLOGIC_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_q   <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      nz_q   <= nz_d;
      zero_q <= zero_d;
    end
  end
  assign zero = zero_q;
`else
  assign zero = 1'b0;
`endif

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign res  = res_q;

endmodule

// File: tb/tb_bitwise_logic_seq.sv
// Scoreboard bench: three instances (SLICE 8, 32, 1) checked against a word-level model.
module tb_bitwise_logic_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_s [3];
  logic [1:0]  op_s    [3];
  logic [31:0] a_s     [3];
  logic [31:0] b_s     [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic [31:0] res_s   [3];
  logic        zero_s  [3];
  logic        prev_done [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int nsl [3]  = '{4, 1, 32};

  typedef struct {
    int          dut;
    logic [31:0] res;
    logic        zero;
    int          acc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bitwise_logic_seq #(.WIDTH(32), .SLICE(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .op(op_s[0]), .a(a_s[0]), .b(b_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .res(res_s[0]), .zero(zero_s[0]));
  bitwise_logic_seq #(.WIDTH(32), .SLICE(32)) u_s32 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .op(op_s[1]), .a(a_s[1]), .b(b_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .res(res_s[1]), .zero(zero_s[1]));
  bitwise_logic_seq #(.WIDTH(32), .SLICE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .op(op_s[2]), .a(a_s[2]), .b(b_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .res(res_s[2]), .zero(zero_s[2]));

  function automatic logic [31:0] model(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  function automatic logic zero_model(logic [31:0] r);
`ifdef BITLOGIC_ZERO_FLAG_EN
    return (r == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string name, int j, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h (t=%0t)", name, j, act, exp, $time);
    end
  endtask

  // Monitor: pops and compares on every done pulse.
  always @(negedge clk) begin
    for (int j = 0; j < 3; j++) begin
      if (done_s[j]) begin
        chk("done_width", j, {31'd0, prev_done[j]}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", j, 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_dut", j, e.dut, j);
          chk("res", j, res_s[j], e.res);
          chk("zero", j, {31'd0, zero_s[j]}, {31'd0, e.zero});
          chk("latency", j, cyc - e.acc, nsl[j]);
        end
      end
      prev_done[j] = done_s[j];
    end
  end

  // Called at a falling edge; returns one falling edge after the accepting edge.
  task automatic issue(int j, logic [1:0] o, logic [31:0] x, logic [31:0] y);
    int t;
    exp_t e;
    t = 0;
    while (busy_s[j] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy_s[j]) chk("busy_timeout", j, 32'd1, 32'd0);
    start_s[j] = 1'b1;
    op_s[j] = o;
    a_s[j] = x;
    b_s[j] = y;
    e.dut = j;
    e.res = model(o, x, y);
    e.zero = zero_model(e.res);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start_s[j] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 0, sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_suite(int j);
    issue(j, 2'd2, 32'h0000_0039, 32'h0000_0003);
    issue(j, 2'd2, 32'h0000_0002, 32'h0000_0001);
    for (int o = 0; o < 4; o++) issue(j, 2'(o), 32'hF0F0_F0F0, 32'hFF00_FF00);
    drain();

    // Start held high and operands scrambled while busy: no restart expected.
    issue(j, 2'd0, 32'hAAAA_AAAA, 32'h5555_5555);
    start_s[j] = 1'b1;
    while (busy_s[j]) begin
      a_s[j] = $urandom;
      b_s[j] = $urandom;
      op_s[j] = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    start_s[j] = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_restart_busy", j, {31'd0, busy_s[j]}, 32'd0);
    chk("hold_res", j, res_s[j], 32'd0);
    chk("hold_zero", j, {31'd0, zero_s[j]}, {31'd0, zero_model(32'd0)});
    drain();

    // Async reset two cycles after accept.
    issue(j, 2'd1, 32'h1234_5678, 32'h8000_0001);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", j, {31'd0, busy_s[j]}, 32'd0);
    chk("rst_done", j, {31'd0, done_s[j]}, 32'd0);
    chk("rst_res", j, res_s[j], 32'd0);
    chk("rst_zero", j, {31'd0, zero_s[j]}, 32'd0);
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(j, 2'd3, 32'h0F0F_0000, 32'h00F0_F000);

    for (int k = 0; k < 12; k++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = (k % 4 == 3) ? ~x : $urandom;
      issue(j, 2'($urandom_range(0, 3)), x, y);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();
  endtask

  initial begin
    for (int j = 0; j < 3; j++) begin
      start_s[j] = 1'b0;
      op_s[j] = 2'd0;
      a_s[j] = 32'd0;
      b_s[j] = 32'd0;
      prev_done[j] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      chk("reset_busy", j, {31'd0, busy_s[j]}, 32'd0);
      chk("reset_done", j, {31'd0, done_s[j]}, 32'd0);
      chk("reset_res", j, res_s[j], 32'd0);
      chk("reset_zero", j, {31'd0, zero_s[j]}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 3; j++) run_suite(j);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
